// File: rtl/spi_master_arbiter.sv
// Shares one MSB-first SPI master engine between NUM_REQ requesters, each with its own cs_n.
// Define SPI_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module spi_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    tx_data,
  input  logic [NUM_REQ-1:0]           cpol,
  input  logic [NUM_REQ-1:0]           cpha,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         busy,
  output logic                         done,
  output logic [DATA_W-1:0]            rx_data,
  output logic [$clog2(NUM_REQ)-1:0]   rx_id,
  output logic                         sclk,
  output logic                         mosi,
  input  logic                         miso,
  output logic [NUM_REQ-1:0]           cs_n
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DIV_W = $clog2(CLK_DIV + 1) + 1;
  localparam int TOG_W = $clog2(2 * DATA_W + 1);

  generate
    if (CLK_DIV < 1) begin : g_div_check
      $error("CLK_DIV must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [TOG_W-1:0]    tog_q, tog_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rxs_q, rxs_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [ID_W-1:0]     rx_id_q, rx_id_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
  logic [ID_W-1:0]     win;

`ifdef SPI_ARB_RR_EN
  logic [ID_W-1:0]     ptr_q, ptr_d;
  int unsigned         rr_idx;

  // Scan from farthest to nearest so the last hit is the first requester after the pointer.
  always_comb begin
    win    = '0;
    rr_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = (32'(ptr_q) + (NUM_REQ - 1 - k)) % NUM_REQ;
      if (req[rr_idx]) win = ID_W'(rr_idx);
    end
  end
`else
  always_comb begin
    win = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (req[k-1]) win = ID_W'(k - 1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tog_q     <= '0;
      tx_q      <= '0;
      rxs_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      id_q      <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      rx_id_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
`ifdef SPI_ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tog_q     <= tog_d;
      tx_q      <= tx_d;
      rxs_q     <= rxs_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      rx_id_q   <= rx_id_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
`ifdef SPI_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tog_d     = tog_q;
    tx_d      = tx_q;
    rxs_d     = rxs_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    id_d      = id_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    rx_id_d   = rx_id_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
`ifdef SPI_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (|req) begin
          gnt_d[win] = 1'b1;
          tx_d       = tx_data[32'(win)*DATA_W +: DATA_W];
          cpol_d     = cpol[win];
          cpha_d     = cpha[win];
          id_d       = win;
          busy_d     = 1'b1;
          sclk_d     = cpol[win];
          cs_n_d     = '1;
          cs_n_d[win] = 1'b0;
          mosi_d     = cpha[win] ? 1'b0 : tx_data[32'(win)*DATA_W + DATA_W - 1];
          rxs_d      = '0;
          div_d      = '0;
          tog_d      = '0;
          state_d    = SETUP;
`ifdef SPI_ARB_RR_EN
          ptr_d      = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
        end
      end
      // The grant cycle itself sits in SETUP, so SETUP spans CLK_DIV+1 cycles.
      SETUP: begin
        if (div_q == DIV_W'(CLK_DIV)) begin
          div_d   = '0;
          state_d = XFER;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      XFER: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d  = '0;
          tog_d  = tog_q + 1'b1;
          sclk_d = ~sclk_q;
          if (tog_d[0]) begin
            if (cpha_q) begin
              mosi_d = tx_q[DATA_W-1];
              tx_d   = tx_q << 1;
            end else begin
              rxs_d = {rxs_q[DATA_W-2:0], miso};
            end
          end else begin
            if (cpha_q) begin
              rxs_d = {rxs_q[DATA_W-2:0], miso};
            end else if (tog_d != TOG_W'(2 * DATA_W)) begin
              mosi_d = tx_q[DATA_W-2];
              tx_d   = tx_q << 1;
            end
          end
          if (tog_d == TOG_W'(2 * DATA_W)) state_d = HOLD;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HOLD: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d     = '0;
          cs_n_d    = '1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rxs_q;
          rx_id_d   = id_q;
          state_d   = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign rx_id   = rx_id_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter at default parameters, miso looped back from mosi.
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] tx_data;
  logic [3:0]  cpol, cpha;
  logic [3:0]  gnt;
  logic        busy, done;
  logic [7:0]  rx_data;
  logic [1:0]  rx_id;
  logic        sclk, mosi, miso;
  logic [3:0]  cs_n;
  logic        miso_tie;

  int checks   = 0;
  int failures = 0;

  assign miso = miso_tie ? 1'b1 : mosi;

  always #5 clk = ~clk;

  spi_master_arbiter #(.NUM_REQ(4), .DATA_W(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .gnt(gnt), .busy(busy), .done(done), .rx_data(rx_data), .rx_id(rx_id),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one transfer for requester idx; req drops and the mode/data inputs are
  // scrambled right after the grant so only latched values can produce the result.
  task automatic do_xfer(input int idx, input logic [7:0] data, input logic pol, input logic pha,
                         output logic [7:0] rx, output logic [1:0] id, output int lat,
                         output int tog, output logic [7:0] mbits, output int idle_bad,
                         output int multi_cs, output int mosi_hi, output bit to);
    int   n;
    logic ps;
    to = 1'b0; lat = 0; tog = 0; mbits = '0; idle_bad = 0; multi_cs = 0; mosi_hi = 0;
    rx = '0; id = '0;
    @(negedge clk);
    tx_data[idx*8 +: 8] = data;
    cpol[idx] = pol;
    cpha[idx] = pha;
    req[idx]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt[idx] !== 1'b1 && n < 20);
    req[idx] = 1'b0;
    if (gnt[idx] !== 1'b1) begin
      to = 1'b1;
      return;
    end
    tx_data[idx*8 +: 8] = ~data;
    cpol[idx] = ~pol;
    cpha[idx] = ~pha;
    ps = sclk;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (sclk !== ps) begin
        tog++;
        if (ps == 1'b0) mbits = {mbits[6:0], mosi};
      end
      ps = sclk;
      if (cs_n[idx] == 1'b0 && (tog == 0 || tog == 16) && sclk !== pol) idle_bad++;
      if ($countones(~cs_n) > 1) multi_cs++;
      if (mosi !== 1'b0) mosi_hi++;
    end
    if (done !== 1'b1) to = 1'b1;
    rx = rx_data;
    id = rx_id;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cs_n !== 4'b1111) begin failures++; $display("FAIL reset_cs_n got=%b exp=1111", cs_n); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if ({rx_data, rx_id} !== 10'h000) begin failures++; $display("FAIL reset_rx got=%h/%0d exp=00/0", rx_data, rx_id); end
  endtask

  task automatic test_basic();
    logic [7:0] rx, mb; logic [1:0] id; int lat, tog, ib, mc, mh; bit to;
    do_xfer(0, 8'hA5, 1'b0, 1'b0, rx, id, lat, tog, mb, ib, mc, mh, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", to); end
    checks++; if (mb !== 8'hA5) begin failures++; $display("FAIL basic_mosi_bits got=%h exp=a5", mb); end
    checks++; if (lat != 37) begin failures++; $display("FAIL basic_latency got=%0d exp=37", lat); end
    checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL basic_rx got=%h exp=a5", rx); end
    checks++; if (id !== 2'd0) begin failures++; $display("FAIL basic_id got=%0d exp=0", id); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=1", busy); end
    checks++; if (cs_n !== 4'b1111) begin failures++; $display("FAIL basic_cs_release got=%b exp=1111", cs_n); end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL basic_after_done got=%b exp=00", {busy, done}); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL basic_rx_held got=%h exp=a5", rx_data); end
  endtask

  task automatic test_modes();
    logic [7:0] rx, mb; logic [1:0] id; int lat, tog, ib, mc, mh; bit to;
    logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b11};
    for (int m = 0; m < 3; m++) begin
      do_xfer(2, 8'h3C, modes[m][1], modes[m][0], rx, id, lat, tog, mb, ib, mc, mh, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL mode%b_timeout got=%b exp=0", modes[m], to); end
      checks++; if (rx !== 8'h3C) begin failures++; $display("FAIL mode%b_rx got=%h exp=3c", modes[m], rx); end
      checks++; if (id !== 2'd2) begin failures++; $display("FAIL mode%b_id got=%0d exp=2", modes[m], id); end
      checks++; if (tog != 16) begin failures++; $display("FAIL mode%b_toggles got=%0d exp=16", modes[m], tog); end
      checks++; if (ib != 0) begin failures++; $display("FAIL mode%b_idle_sclk got=%0d exp=0", modes[m], ib); end
      checks++; if (lat != 37) begin failures++; $display("FAIL mode%b_latency got=%0d exp=37", modes[m], lat); end
      checks++; if (sclk !== modes[m][1]) begin failures++; $display("FAIL mode%b_sclk_park got=%b exp=%b", modes[m], sclk, modes[m][1]); end
    end
  endtask

  task automatic test_miso_ones();
    logic [7:0] rx, mb; logic [1:0] id; int lat, tog, ib, mc, mh; bit to;
    miso_tie = 1'b1;
    do_xfer(1, 8'h00, 1'b0, 1'b0, rx, id, lat, tog, mb, ib, mc, mh, to);
    miso_tie = 1'b0;
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL ones_timeout got=%b exp=0", to); end
    checks++; if (rx !== 8'hFF) begin failures++; $display("FAIL ones_rx got=%h exp=ff", rx); end
    checks++; if (mh != 0) begin failures++; $display("FAIL ones_mosi_high got=%0d exp=0", mh); end
    checks++; if (mc != 0) begin failures++; $display("FAIL ones_multi_cs got=%0d exp=0", mc); end
  endtask

  task automatic test_pulse_req3();
    logic [7:0] rx, mb; logic [1:0] id; int lat, tog, ib, mc, mh; bit to;
    int extra_done = 0, extra_gnt = 0;
    do_xfer(3, 8'h96, 1'b0, 1'b1, rx, id, lat, tog, mb, ib, mc, mh, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL pulse_timeout got=%b exp=0", to); end
    checks++; if (rx !== 8'h96) begin failures++; $display("FAIL pulse_rx got=%h exp=96", rx); end
    checks++; if (id !== 2'd3) begin failures++; $display("FAIL pulse_id got=%0d exp=3", id); end
    repeat (45) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
      if (gnt !== 4'b0000) extra_gnt++;
    end
    checks++; if (extra_done != 0) begin failures++; $display("FAIL pulse_extra_done got=%0d exp=0", extra_done); end
    checks++; if (extra_gnt != 0) begin failures++; $display("FAIL pulse_extra_gnt got=%0d exp=0", extra_gnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, mb; logic [1:0] id; int lat, tog, ib, mc, mh; bit to;
    int n = 0, rises = 0, late_done = 0;
    logic ps;
    @(negedge clk);
    tx_data[23:16] = 8'hC3; cpol[2] = 1'b0; cpha[2] = 1'b0; req[2] = 1'b1;
    do begin @(negedge clk); n++; end while (gnt[2] !== 1'b1 && n < 20);
    req[2] = 1'b0;
    ps = sclk;
    n = 0;
    while (rises < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (ps == 1'b0 && sclk == 1'b1) rises++;
      ps = sclk;
    end
    checks++; if (rises != 4) begin failures++; $display("FAIL rstmid_reach_edge got=%0d exp=4", rises); end
    rst_n = 1'b0;
    #1;
    checks++; if (cs_n !== 4'b1111) begin failures++; $display("FAIL rstmid_cs_n got=%b exp=1111", cs_n); end
    checks++; if ({sclk, busy, done} !== 3'b000) begin failures++; $display("FAIL rstmid_sclk_busy_done got=%b exp=000", {sclk, busy, done}); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_rx got=%h exp=00", rx_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) late_done++;
    end
    checks++; if (late_done != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", late_done); end
    do_xfer(1, 8'h5A, 1'b0, 1'b0, rx, id, lat, tog, mb, ib, mc, mh, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL rstmid_next_timeout got=%b exp=0", to); end
    checks++; if ({rx, id} !== {8'h5A, 2'd1}) begin failures++; $display("FAIL rstmid_next_rx got=%h/%0d exp=5a/1", rx, id); end
  endtask

  task automatic test_arbitration();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
    int exp_idx, n;
    apply_reset();
    cpol = 4'b0000; cpha = 4'b0000;
    tx_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
`ifdef SPI_ARB_RR_EN
      exp_idx = g % 4;
`else
      exp_idx = 0;
`endif
      n = 0;
      do begin @(negedge clk); n++; end while (gnt === 4'b0000 && n < 60);
      checks++; if (gnt !== (4'b0001 << exp_idx)) begin failures++; $display("FAIL arb_gnt%0d got=%b exp=%b", g, gnt, 4'b0001 << exp_idx); end
      n = 0;
      do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 60);
      checks++; if ({rx_data, rx_id} !== {bytes[exp_idx], 2'(exp_idx)}) begin
        failures++; $display("FAIL arb_rx%0d got=%h/%0d exp=%h/%0d", g, rx_data, rx_id, bytes[exp_idx], exp_idx);
      end
    end
    req = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; tx_data = '0; cpol = '0; cpha = '0; miso_tie = 1'b0;
    test_reset();
    test_basic();
    test_modes();
    test_miso_ones();
    test_pulse_req3();
    test_reset_mid();
    test_arbitration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
